// File: rtl/mode_sequencer_pkg.sv
// Shared defaults and types for the push-button mode sequencer.
// Mode encodings, default sizing and inter-stage bundles.
package mode_sequencer_pkg;

  localparam int DEF_NUM_MODES = 3;
  localparam int DEF_DEBOUNCE  = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SMALL = 2'd1,
    MODE_LARGE = 2'd2
  } mode_e;

  typedef struct packed {
    logic nxt;
    logic prv;
  } step_req_t;

  typedef struct packed {
    logic changed;
    logic wrapped;
    logic blocked;
  } status_t;

  function automatic logic idle_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/mode_sequencer_btn_conditioner.sv
// Raw button -> synchronised, debounced, single-cycle press pulse.
// A button held through reset never produces a press until released.
module btn_conditioner
  import mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam logic IDLE = idle_level(ACTIVE_LOW);
  localparam int   CW   =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;
  logic          started;
  logic          armed;

  // two-flop synchroniser for the asynchronous raw input
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // accept a new level only after it is stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= IDLE;
      cnt <= '0;
    end else if (s2 != deb) begin
      if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // arm only once the real input has been seen idle after reset,
  // so a button held through reset is not taken as a press
  always_ff @(posedge clk) begin
    if (rst) begin
      started <= 1'b0;
      armed   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (started && s1 == IDLE)
        armed <= 1'b1;
    end
  end

  // one-cycle pulse on the idle->active edge of the debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_d <= IDLE;
      press <= 1'b0;
    end else begin
      deb_d <= deb;
      press <= armed && (deb != IDLE) && (deb_d == IDLE);
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Two push-buttons step a registered mode index up or down.
// Wraps or saturates at the ends and emits aligned status pulses.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int NUM_MODES       = DEF_NUM_MODES,
  parameter int W               = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter bit WRAP            = 1'b1,
  parameter int RESET_MODE      = 0,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_next,
  input  logic         btn_prev,
  output logic [W-1:0] control,
  output logic         changed,
  output logic         wrapped,
  output logic         blocked
);

  localparam logic [W-1:0] RST_M = W'(RESET_MODE);
  localparam logic [W:0]   LAST  = (W+1)'(NUM_MODES - 1);

  step_req_t    req;
  logic [W-1:0] mode;
  logic [W-1:0] mode_n;
  status_t      st_n;
  status_t      st_q;
  logic [W:0]   m_ext;
  logic [W:0]   m_inc;
  logic [W:0]   m_dec;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .press (req.nxt)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_prev (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_prev),
    .press (req.prv)
  );

  // step arithmetic one bit wider so the end test is exact
  always_comb begin
    mode_n = mode;
    st_n   = '0;
    m_ext  = {1'b0, mode};
    m_inc  = m_ext + (W+1)'(1);
    m_dec  = m_ext - (W+1)'(1);
    unique case (1'b1)
      req.nxt && !req.prv: begin
        if (m_ext == LAST) begin
          if (WRAP) begin
            mode_n       = '0;
            st_n.changed = 1'b1;
            st_n.wrapped = 1'b1;
          end else begin
            st_n.blocked = 1'b1;
          end
        end else begin
          mode_n       = m_inc[W-1:0];
          st_n.changed = 1'b1;
        end
      end
      req.prv && !req.nxt: begin
        if (m_ext == '0) begin
          if (WRAP) begin
            mode_n       = LAST[W-1:0];
            st_n.changed = 1'b1;
            st_n.wrapped = 1'b1;
          end else begin
            st_n.blocked = 1'b1;
          end
        end else begin
          mode_n       = m_dec[W-1:0];
          st_n.changed = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // mode counter and its status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= RST_M;
      st_q <= '0;
    end else begin
      mode <= mode_n;
      st_q <= st_n;
    end
  end

  // output stage keeps pulses aligned with control
  always_ff @(posedge clk) begin
    if (rst) begin
      control <= RST_M;
      changed <= 1'b0;
      wrapped <= 1'b0;
      blocked <= 1'b0;
    end else begin
      control <= mode;
      changed <= st_q.changed;
      wrapped <= st_q.wrapped;
      blocked <= st_q.blocked;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: wrap, saturate and 5-mode builds.
// Vector table for single operations plus hand-written corner sequences.
module tb_mode_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] bn;
  logic [2:0] bp;
  logic [1:0] ca;
  logic [1:0] cb;
  logic [2:0] cc;
  logic [2:0] chg;
  logic [2:0] wrp;
  logic [2:0] blk;
  bit         over;

  int tests;
  int fails;

  mode_sequencer #(
    .NUM_MODES(3), .W(2), .DEBOUNCE_CYCLES(4),
    .WRAP(1'b1), .RESET_MODE(0), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_next(bn[0]), .btn_prev(bp[0]),
    .control(ca), .changed(chg[0]), .wrapped(wrp[0]),
    .blocked(blk[0])
  );

  mode_sequencer #(
    .NUM_MODES(3), .W(2), .DEBOUNCE_CYCLES(4),
    .WRAP(1'b0), .RESET_MODE(0), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_next(bn[1]), .btn_prev(bp[1]),
    .control(cb), .changed(chg[1]), .wrapped(wrp[1]),
    .blocked(blk[1])
  );

  mode_sequencer #(
    .NUM_MODES(5), .W(3), .DEBOUNCE_CYCLES(4),
    .WRAP(1'b1), .RESET_MODE(0), .ACTIVE_LOW(1'b1)
  ) dut_c (
    .clk(clk), .rst(rst), .btn_next(bn[2]), .btn_prev(bp[2]),
    .control(cc), .changed(chg[2]), .wrapped(wrp[2]),
    .blocked(blk[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (!rst && cc >= 3'd5)
      over = 1'b1;
  end

  // ops: 0 next, 1 prev, 2 both, 3 glitch, 4 bounce, 5 apart
  typedef struct {
    int d;
    int op;
    int hold;
    int e_ctrl;
    int e_chg;
    int e_wrp;
    int e_blk;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int ctrl(input int d);
    case (d)
      0:       return int'(ca);
      1:       return int'(cb);
      default: return int'(cc);
    endcase
  endfunction

  function automatic bit nxt_act(input int op, input int k,
                                 input int hold);
    case (op)
      0, 2, 5: return k < hold;
      3:       return k < 3;
      4:       return (k < 3) || (k >= 4 && k < 14);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit prv_act(input int op, input int k,
                                 input int hold);
    case (op)
      1, 2: return k < hold;
      5:    return (k >= 3) && (k < 3 + hold);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_op(input int d, input int op,
                        input int hold, output int nc,
                        output int nw, output int nb);
    nc = 0;
    nw = 0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bn[d] = ~nxt_act(op, k, hold);
      bp[d] = ~prv_act(op, k, hold);
      @(posedge clk);
      #1;
      nc += int'(chg[d]);
      nw += int'(wrp[d]);
      nb += int'(blk[d]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
  endtask

  initial begin
    int nc;
    int nw;
    int nb;
    int edge_at;
    int chg_at;
    tests = 0;
    fails = 0;
    over  = 1'b0;
    bn    = 3'b111;
    bp    = 3'b111;
    rst   = 1'b1;

    vt.push_back('{0, 0, 20, 2, 1, 0, 0});
    vt.push_back('{0, 0, 20, 0, 1, 1, 0});
    vt.push_back('{0, 4, 0,  1, 1, 0, 0});
    vt.push_back('{0, 3, 0,  1, 0, 0, 0});
    vt.push_back('{0, 1, 20, 0, 1, 0, 0});
    vt.push_back('{0, 1, 20, 2, 1, 1, 0});
    vt.push_back('{0, 2, 20, 2, 0, 0, 0});
    vt.push_back('{0, 5, 10, 2, 2, 2, 0});
    vt.push_back('{1, 1, 20, 0, 0, 0, 1});
    vt.push_back('{1, 0, 20, 1, 1, 0, 0});
    vt.push_back('{1, 0, 20, 2, 1, 0, 0});
    vt.push_back('{1, 0, 20, 2, 0, 0, 1});
    vt.push_back('{2, 0, 20, 1, 1, 0, 0});
    vt.push_back('{2, 0, 20, 2, 1, 0, 0});
    vt.push_back('{2, 0, 20, 3, 1, 0, 0});
    vt.push_back('{2, 0, 20, 4, 1, 0, 0});
    vt.push_back('{2, 0, 20, 0, 1, 1, 0});
    vt.push_back('{2, 0, 20, 1, 1, 0, 0});

    // reset with idle buttons
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ctrl_a", int'(ca), 0);
    chk("rst_ctrl_b", int'(cb), 0);
    chk("rst_ctrl_c", int'(cc), 0);
    chk("rst_chg", int'(chg), 0);
    chk("rst_wrp", int'(wrp), 0);
    chk("rst_blk", int'(blk), 0);

    // button held through reset release is not a press
    @(negedge clk);
    bn[0] = 1'b0;
    rst   = 1'b1;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    nc  = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      nc += int'(chg[0]);
    end
    chk("held_rst_ctrl", int'(ca), 0);
    chk("held_rst_chg", nc, 0);
    @(negedge clk);
    bn[0] = 1'b1;
    idle(12);

    // latency of a clean press: control moves on edge 9
    @(negedge clk);
    bn[0]   = 1'b0;
    edge_at = 0;
    chg_at  = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (edge_at == 0 && ca != 2'd0) begin
        edge_at = k;
        chg_at  = int'(chg[0]);
      end
      if (k == 20)
        bn[0] = 1'b1;
    end
    chk("lat_edge", edge_at, 9);
    chk("lat_changed", chg_at, 1);
    chk("lat_ctrl", int'(ca), 1);

    foreach (vt[i]) begin
      run_op(vt[i].d, vt[i].op, vt[i].hold, nc, nw, nb);
      chk($sformatf("v%0d_ctrl", i), ctrl(vt[i].d),
          vt[i].e_ctrl);
      chk($sformatf("v%0d_changed", i), nc, vt[i].e_chg);
      chk($sformatf("v%0d_wrapped", i), nw, vt[i].e_wrp);
      chk($sformatf("v%0d_blocked", i), nb, vt[i].e_blk);
    end

    chk("c_never_over", int'(over), 0);

    // reset shortly after a press discards the step
    @(negedge clk);
    bn[2] = 1'b0;
    idle(6);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    rst   = 1'b0;
    bn[2] = 1'b1;
    nc    = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      nc += int'(chg[2]);
    end
    chk("midrst_ctrl", int'(cc), 0);
    chk("midrst_chg", nc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
